// File: rtl/imem_loader.sv
// Boot loader: receives a byte-stream program image (count, data, XOR checksum),
// writes it word by word into the instruction memory and owns the core's reset release.
module imem_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int                IDX_W   = $clog2(DEPTH + 1);
    localparam logic [31:0]       DEPTH_W = 32'(DEPTH);
    localparam logic [IDX_W-1:0]  ONE     = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        xor_q, xor_d;
    logic              we_q, we_d;
    logic [31:0]       waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              in_load;
    logic              accept;
    logic [31:0]       full_word;

    assign in_load   = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CSUM);
    assign accept    = byte_valid && in_load;
    // The first three bytes sit in asm_q; the arriving byte completes the little-endian word.
    assign full_word = {byte_data, asm_q};

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        n_d       = n_q;
        idx_d     = idx_q;
        xor_d     = xor_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d   = S_HDR;
                    cnt_d     = 2'd0;
                    idx_d     = '0;
                    xor_d     = 8'h00;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cpu_rst_d = 1'b1;
                end
            end
            S_HDR: begin
                if (accept) begin
                    cnt_d = cnt_q + 2'd1;
                    asm_d = {byte_data, asm_q[23:8]};
                    if (cnt_q == 2'd3) begin
                        if (full_word == 32'd0) begin
                            state_d = S_CSUM;
                        end else if (full_word > DEPTH_W) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_LOAD;
                            n_d     = full_word[IDX_W-1:0];
                        end
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 2'd1;
                    asm_d = {byte_data, asm_q[23:8]};
                    xor_d = xor_q ^ byte_data;
                    if (cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = full_word;
                        waddr_d = BASE_ADDR + 32'({idx_q, 2'b00});
                        idx_d   = idx_q + ONE;
                        if (idx_q == n_q - ONE) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (byte_data == xor_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            asm_q     <= 24'd0;
            n_q       <= '0;
            idx_q     <= '0;
            xor_q     <= 8'h00;
            we_q      <= 1'b0;
            waddr_q   <= 32'd0;
            wdata_q   <= 32'd0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            xor_q     <= xor_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign byte_ready = in_load;
    assign busy       = in_load;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (BASE_ADDR 0 and 0x100) share one
// byte stream; a negedge monitor records every write strobe for later comparison.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        d0_byte_ready, d0_we, d0_cpu_rst, d0_busy, d0_done, d0_err;
    logic [31:0] d0_waddr, d0_wdata;
    logic        d1_byte_ready, d1_we, d1_cpu_rst, d1_busy, d1_done, d1_err;
    logic [31:0] d1_waddr, d1_wdata;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] wq0[$];
    logic [63:0] wq1[$];
    logic        prev_we1 = 1'b0;
    int          wide_seen = 0;
    logic [7:0]  acc;

    imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(d0_byte_ready), .we(d0_we), .waddr(d0_waddr), .wdata(d0_wdata),
        .cpu_rst(d0_cpu_rst), .busy(d0_busy), .done(d0_done), .err(d0_err)
    );

    imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0100)) dut1 (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(d1_byte_ready), .we(d1_we), .waddr(d1_waddr), .wdata(d1_wdata),
        .cpu_rst(d1_cpu_rst), .busy(d1_busy), .done(d1_done), .err(d1_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (d0_we) wq0.push_back({d0_waddr, d0_wdata});
        if (d1_we) wq1.push_back({d1_waddr, d1_wdata});
        if (d1_we && prev_we1) wide_seen <= wide_seen + 1;
        prev_we1 <= d1_we;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_count(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            acc = acc ^ w[8*i +: 8];
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({d0_we, d0_waddr, d0_wdata} !== 65'd0) begin
            fails++;
            $display("FAIL reset_write_port: got we=%b waddr=%h wdata=%h want all zero", d0_we, d0_waddr, d0_wdata);
        end
        tests++;
        if ({d0_cpu_rst, d0_busy, d0_done, d0_err, d0_byte_ready} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_status: got cpu_rst,busy,done,err,ready=%b want 10000",
                     {d0_cpu_rst, d0_busy, d0_done, d0_err, d0_byte_ready});
        end
        rst = 1'b0;
        byte_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        tests++;
        if ({d0_byte_ready, d0_busy, d0_cpu_rst} !== 3'b001 || wq0.size() != 0) begin
            fails++;
            $display("FAIL idle_ignores_bytes: got ready,busy,cpu_rst=%b writes=%0d want 001 and 0",
                     {d0_byte_ready, d0_busy, d0_cpu_rst}, wq0.size());
        end
    endtask

    task automatic test_two_word();
        wq0.delete();
        acc = 8'h00;
        pulse_start();
        tests++;
        if ({d0_byte_ready, d0_busy, d0_cpu_rst} !== 3'b111) begin
            fails++;
            $display("FAIL start_latency: got ready,busy,cpu_rst=%b want 111", {d0_byte_ready, d0_busy, d0_cpu_rst});
        end
        send_count(32'd2);
        send_word(32'h0010_0513);
        tests++;
        if ({d0_we, d0_waddr, d0_wdata} !== {1'b1, 32'h0, 32'h0010_0513}) begin
            fails++;
            $display("FAIL first_write: got we=%b waddr=%h wdata=%h want 1 00000000 00100513", d0_we, d0_waddr, d0_wdata);
        end
        send_word(32'h0020_0593);
        tests++;
        if ({d0_we, d0_waddr, d0_wdata, d0_busy} !== {1'b1, 32'h4, 32'h0020_0593, 1'b1}) begin
            fails++;
            $display("FAIL second_write: got we=%b waddr=%h wdata=%h busy=%b want 1 00000004 00200593 1",
                     d0_we, d0_waddr, d0_wdata, d0_busy);
        end
        // Checksum byte lands in the same cycle as the last write strobe; XOR of the data is 0xB0.
        send_byte(8'hB0);
        tests++;
        if ({d0_done, d0_cpu_rst, d0_busy, d0_err, d0_we} !== 5'b10000) begin
            fails++;
            $display("FAIL two_word_done: got done,cpu_rst,busy,err,we=%b want 10000",
                     {d0_done, d0_cpu_rst, d0_busy, d0_err, d0_we});
        end
        tests++;
        if (wq0.size() != 2) begin
            fails++;
            $display("FAIL two_word_count: got %0d writes want 2", wq0.size());
        end else if (wq0[0] !== {32'h0, 32'h0010_0513} || wq0[1] !== {32'h4, 32'h0020_0593}) begin
            fails++;
            $display("FAIL two_word_log: got %h %h want 0000000000100513 0000000400200593", wq0[0], wq0[1]);
        end
    endtask

    task automatic test_zero_length();
        wq0.delete();
        pulse_start();
        tests++;
        if ({d0_done, d0_cpu_rst, d0_busy} !== 3'b011) begin
            fails++;
            $display("FAIL restart_clears_done: got done,cpu_rst,busy=%b want 011", {d0_done, d0_cpu_rst, d0_busy});
        end
        send_count(32'd0);
        tests++;
        if ({d0_busy, d0_byte_ready, d0_done} !== 3'b110) begin
            fails++;
            $display("FAIL zero_awaits_csum: got busy,ready,done=%b want 110", {d0_busy, d0_byte_ready, d0_done});
        end
        send_byte(8'h00);
        tests++;
        if ({d0_done, d0_cpu_rst, d0_err} !== 3'b100 || wq0.size() != 0) begin
            fails++;
            $display("FAIL zero_length: got done,cpu_rst,err=%b writes=%0d want 100 and 0",
                     {d0_done, d0_cpu_rst, d0_err}, wq0.size());
        end
    endtask

    task automatic test_oversize();
        wq0.delete();
        pulse_start();
        send_count(32'd257);
        tests++;
        if ({d0_err, d0_cpu_rst, d0_byte_ready, d0_busy, d0_done} !== 5'b11000) begin
            fails++;
            $display("FAIL oversize: got err,cpu_rst,ready,busy,done=%b want 11000",
                     {d0_err, d0_cpu_rst, d0_byte_ready, d0_busy, d0_done});
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (d0_err !== 1'b1 || wq0.size() != 0) begin
            fails++;
            $display("FAIL oversize_no_write: got err=%b writes=%0d want 1 and 0", d0_err, wq0.size());
        end
    endtask

    task automatic test_csum_mismatch();
        wq0.delete();
        acc = 8'h00;
        pulse_start();
        tests++;
        if ({d0_err, d0_busy} !== 2'b01) begin
            fails++;
            $display("FAIL restart_clears_err: got err,busy=%b want 01", {d0_err, d0_busy});
        end
        send_count(32'd2);
        send_word(32'h0010_0513);
        send_word(32'h0020_0593);
        send_byte(8'h81);
        tests++;
        if ({d0_err, d0_done, d0_cpu_rst, d0_busy} !== 4'b1010) begin
            fails++;
            $display("FAIL csum_mismatch: got err,done,cpu_rst,busy=%b want 1010",
                     {d0_err, d0_done, d0_cpu_rst, d0_busy});
        end
        tests++;
        if (wq0.size() != 2 || wq0[0] !== {32'h0, 32'h0010_0513} || wq0[1] !== {32'h4, 32'h0020_0593}) begin
            fails++;
            $display("FAIL mismatch_writes: got %0d writes want 2 with the image words", wq0.size());
        end
    endtask

    task automatic test_gaps();
        logic [31:0] img [4];
        logic [31:0] w;
        img[0] = 32'h0010_0513;
        img[1] = 32'h0020_0593;
        img[2] = 32'h00B5_0633;
        img[3] = 32'h0000_006F;
        wq1.delete();
        wide_seen = 0;
        acc = 8'h00;
        pulse_start();
        send_count(32'd4);
        for (int k = 0; k < 4; k++) begin
            w = img[k];
            for (int b = 0; b < 4; b++) begin
                if (k == 2 && b == 0) pulse_start();
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1;
                acc = acc ^ w[8*b +: 8];
                send_byte(w[8*b +: 8]);
            end
        end
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
        send_byte(acc);
        tests++;
        if ({d1_done, d1_cpu_rst, d1_err} !== 3'b100) begin
            fails++;
            $display("FAIL gaps_done: got done,cpu_rst,err=%b want 100", {d1_done, d1_cpu_rst, d1_err});
        end
        tests++;
        if (wq1.size() != 4) begin
            fails++;
            $display("FAIL gaps_count: got %0d writes want 4", wq1.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wq1[k] !== {32'h100 + 32'(4 * k), img[k]}) begin
                    fails++;
                    $display("FAIL gaps_write%0d: got %h want %h", k, wq1[k], {32'h100 + 32'(4 * k), img[k]});
                end
            end
        end
        tests++;
        if (wide_seen != 0) begin
            fails++;
            $display("FAIL we_width: got %0d multi-cycle strobes want 0", wide_seen);
        end
    endtask

    task automatic test_reset_mid_load();
        wq0.delete();
        pulse_start();
        send_count(32'd2);
        send_byte(8'h13);
        send_byte(8'h05);
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({d0_we, d0_waddr, d0_wdata, d0_cpu_rst, d0_busy, d0_done, d0_err, d0_byte_ready}
                !== {1'b0, 32'h0, 32'h0, 5'b10000}) begin
            fails++;
            $display("FAIL mid_reset_values: got we=%b waddr=%h wdata=%h status=%b want 0 0 0 10000",
                     d0_we, d0_waddr, d0_wdata, {d0_cpu_rst, d0_busy, d0_done, d0_err, d0_byte_ready});
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (wq0.size() != 0) begin
            fails++;
            $display("FAIL mid_reset_no_write: got %0d writes want 0", wq0.size());
        end
        acc = 8'h00;
        pulse_start();
        send_count(32'd1);
        send_word(32'hDEAD_BEEF);
        send_byte(acc);
        tests++;
        if (wq0.size() != 1 || wq0[0] !== {32'h0, 32'hDEAD_BEEF} || {d0_done, d0_cpu_rst} !== 2'b10) begin
            fails++;
            $display("FAIL restart_load: got writes=%0d done,cpu_rst=%b want 1 write at 0 and 10",
                     wq0.size(), {d0_done, d0_cpu_rst});
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_two_word();
        test_zero_length();
        test_oversize();
        test_csum_mismatch();
        test_gaps();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
